decode_issue_stage: RTL and testbench
=====================================

// Module: decode_issue_stage
// PURPOSE
//  RV32I decode/issue stage between the fetch buffer and execute.
//  - Drives rs1/rs2 to the register file and receives the combinational r1/r2 read data.
//  - Resolves operands by forwarding from EX, MEM and WB, and generates the immediate.
//  - Detects load-use hazards and registers the decoded bundle into the ID/EX boundary.
//  - Stall and flush handshakes coordinate it with fetch and execute.
// PARAMETERS
//  XLEN     32  datapath width
//  RESET_PC 0   value of ex_pc after reset
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     asynchronous reset, active high
//  id_valid     in   1     id_instr/id_pc hold a live instruction
//  id_instr     in   32    instruction word
//  id_pc        in   XLEN  instruction address
//  flush        in   1     kill the ID/EX contents (branch redirect)
//  stall_in     in   1     execute cannot accept; hold the ID/EX register
//  stall_out    out  1     fetch must hold id_instr/id_pc
//  rf_rs1       out  5     register-file read index 1 (id_instr[19:15])
//  rf_rs2       out  5     register-file read index 2 (id_instr[24:20])
//  rf_r1        in   XLEN  register-file read data 1 (combinational)
//  rf_r2        in   XLEN  register-file read data 2 (combinational)
//  ex_fwd_rd    in   5     destination register of the instruction now in EX
//  ex_fwd_wen   in   1     EX instruction writes a register
//  ex_fwd_load  in   1     EX instruction is a load (result not yet available)
//  ex_fwd_data  in   XLEN  EX result
//  mem_fwd_rd   in   5     destination register of the instruction in MEM
//  mem_fwd_wen  in   1     MEM instruction writes a register
//  mem_fwd_data in   XLEN  MEM result
//  wb_rd        in   5     WB destination; same signals drive the register-file write port
//  wb_wen       in   1     WB write enable
//  wb_data      in   XLEN  WB write data
//  ex_valid     out  1     ID/EX bundle is live
//  ex_pc        out  XLEN  registered pc
//  ex_op1       out  XLEN  resolved rs1 value
//  ex_op2       out  XLEN  resolved rs2 value
//  ex_imm       out  XLEN  sign-extended immediate
//  ex_rd        out  5     destination register; 0 if the instruction type does not write
//  ex_opcode    out  7     opcode; ex_funct3 out 3; ex_funct7b5 out 1 (instr[30])
//  ex_is_load   out  1     opcode == LOAD
// BEHAVIOUR
//  - Reset (async): ex_valid=0, ex_pc=RESET_PC, every other registered output=0.
//  - Operand use:
//    - rs1 is used by all opcodes except LUI, AUIPC and JAL.
//    - rs2 is used only by OP, STORE and BRANCH.
//  - Forwarding (combinational, per operand), highest priority first:
//    EX (if not a load) > MEM > WB > rf_r1/rf_r2.
//    - A source matches only if its wen is 1, its rd equals the index, and the index != 0.
//    - x0 always reads 0, regardless of any forwarding match.
//    - WB bypass is required: the register file writes at the clock edge, so its read data lags WB by one cycle.
//  - Hazard: hz = id_valid & ex_fwd_load & ex_fwd_wen & ex_fwd_rd!=0 & the matching operand is used.
//  - stall_out = stall_in | (hz & ~flush).
//  - ID/EX register update each edge, in priority order:
//    1. flush: ex_valid<=0, other fields don't-care. flush beats stall_in.
//    2. stall_in: hold every field.
//    3. hz: ex_valid<=0 (bubble), ex_rd<=0, ex_is_load<=0.
//    4. otherwise: capture the decoded bundle, with ex_valid<=id_valid.
//  - Latency: one cycle from id_* to ex_*. A load-use dependency costs exactly one bubble.
//  - Immediates by opcode: I-type (OP-IMM, LOAD, JALR), S, B, U, J; sign-extended to XLEN.
//    Other opcodes give imm=0.
//  - Illegal opcode: passes through with ex_rd=0 (no write). Trap handling is done downstream.
//  - Reset asserted mid-stall: state clears immediately and stall_out follows its inputs.
// STRUCTURE
//  - Shared package rv32_pkg: opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
//    LUI, AUIPC) and a function for immediate type selection.
//  - Sub-module imm_gen (instr -> imm), combinational.
//  - Forwarding muxes and hazard logic stay inline in this module.
// TESTING
//  - Reset:
//    rst=1 mid-run -> ex_valid=0 and ex_pc=RESET_PC in the same cycle, stall_out=0.
//  - EX forwarding:
//    `add x3,x1,x2` with ex_fwd_rd=1, ex_fwd_data=0x55 and rf_r1=0x11 -> ex_op1=0x55.
//  - Forwarding priority:
//    EX, MEM and WB all target x1 (0xA, 0xB, 0xC) -> ex_op1=0xA.
//    Drop EX -> 0xB. Drop MEM -> 0xC.
//  - x0 is never forwarded:
//    `addi x5,x0,7` with ex_fwd_rd=0, ex_fwd_wen=1, ex_fwd_data=0xFF -> ex_op1=0, ex_imm=7.
//  - Load-use:
//    `lw x1` in EX, then `add x2,x1,x1` -> stall_out=1 for 1 cycle and one bubble (ex_valid=0).
//    The add issues the next cycle.
//    `lui x1` after the same load -> no stall (rs1 unused).
//  - flush with stall_in=1 -> ex_valid=0 next cycle.
//  - stall_in alone for 3 cycles -> all ex_* held, stall_out=1 throughout.

Source files
------------

// File: rtl/rv32_pkg.sv
// RV32I opcode constants, immediate-format selection and per-opcode operand/writeback classification.
package rv32_pkg;

    localparam int unsigned ILEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OPC_W  = 7;

    localparam logic [OPC_W-1:0] OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_type_e;

    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic writes_rd;
        logic is_load;
    } op_class_t;

    function automatic imm_type_e imm_type(input logic [OPC_W-1:0] opcode);
        imm_type_e t;
        case (opcode)
            OP_IMM, LOAD, JALR: t = IMM_I;
            STORE:              t = IMM_S;
            BRANCH:             t = IMM_B;
            LUI, AUIPC:         t = IMM_U;
            JAL:                t = IMM_J;
            default:            t = IMM_NONE;
        endcase
        return t;
    endfunction

    // Unknown opcodes still read rs1 (conservative for hazards) but never write rd.
    function automatic op_class_t op_class(input logic [OPC_W-1:0] opcode);
        op_class_t c;
        c.rs1_used  = !(opcode inside {LUI, AUIPC, JAL});
        c.rs2_used  = opcode inside {OP, STORE, BRANCH};
        c.writes_rd = opcode inside {OP, OP_IMM, LOAD, JAL, JALR, LUI, AUIPC};
        c.is_load   = (opcode == LOAD);
        return c;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to XLEN.
module imm_gen
    import rv32_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] imm_c
);

    logic [ILEN-1:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_type(instr[6:0]))
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_c = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue: operand forwarding, load-use interlock and the ID/EX pipeline register.
module decode_issue_stage
    import rv32_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [ILEN-1:0]  id_instr,
    input  logic [XLEN-1:0]  id_pc,
    input  logic             flush,
    input  logic             stall_in,
    output logic             stall_out,
    output logic [REG_W-1:0] rf_rs1,
    output logic [REG_W-1:0] rf_rs2,
    input  logic [XLEN-1:0]  rf_r1,
    input  logic [XLEN-1:0]  rf_r2,
    input  logic [REG_W-1:0] ex_fwd_rd,
    input  logic             ex_fwd_wen,
    input  logic             ex_fwd_load,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic [REG_W-1:0] mem_fwd_rd,
    input  logic             mem_fwd_wen,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_wen,
    input  logic [XLEN-1:0]  wb_data,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_rd,
    output logic [OPC_W-1:0] ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_is_load
);

    logic [OPC_W-1:0]           opcode;
    op_class_t                  cls;
    logic [1:0][REG_W-1:0]      src_idx;
    logic [1:0][XLEN-1:0]       src_rf;
    logic [1:0][XLEN-1:0]       opnd_c;
    logic [XLEN-1:0]            imm_c;
    logic                       hz_c;

    assign opcode     = id_instr[6:0];
    assign cls        = op_class(opcode);
    assign rf_rs1     = id_instr[19:15];
    assign rf_rs2     = id_instr[24:20];
    assign src_idx[0] = id_instr[19:15];
    assign src_idx[1] = id_instr[24:20];
    assign src_rf[0]  = rf_r1;
    assign src_rf[1]  = rf_r2;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (id_instr),
        .imm_c (imm_c)
    );

    // Youngest producer wins; a load still in EX has no data yet and is covered by the interlock.
    always_comb begin
        opnd_c = '0;
        for (int i = 0; i < 2; i++) begin
            if (src_idx[i] == '0)
                opnd_c[i] = '0;
            else if (ex_fwd_wen && !ex_fwd_load && ex_fwd_rd == src_idx[i])
                opnd_c[i] = ex_fwd_data;
            else if (mem_fwd_wen && mem_fwd_rd == src_idx[i])
                opnd_c[i] = mem_fwd_data;
            else if (wb_wen && wb_rd == src_idx[i])
                opnd_c[i] = wb_data;
            else
                opnd_c[i] = src_rf[i];
        end
    end

    assign hz_c = id_valid && ex_fwd_load && ex_fwd_wen && (ex_fwd_rd != '0) &&
                  ((cls.rs1_used && src_idx[0] == ex_fwd_rd) ||
                   (cls.rs2_used && src_idx[1] == ex_fwd_rd));

    assign stall_out = stall_in | (hz_c & ~flush);

    // ID/EX register: flush > stall_in > load-use bubble > capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= RESET_PC;
            ex_op1      <= '0;
            ex_op2      <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_is_load  <= 1'b0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_rd      <= '0;
            ex_is_load <= 1'b0;
        end else if (!stall_in) begin
            if (hz_c) begin
                ex_valid   <= 1'b0;
                ex_rd      <= '0;
                ex_is_load <= 1'b0;
            end else begin
                ex_valid    <= id_valid;
                ex_pc       <= id_pc;
                ex_op1      <= opnd_c[0];
                ex_op2      <= opnd_c[1];
                ex_imm      <= imm_c;
                ex_rd       <= cls.writes_rd ? id_instr[11:7] : '0;
                ex_opcode   <= opcode;
                ex_funct3   <= id_instr[14:12];
                ex_funct7b5 <= id_instr[30];
                ex_is_load  <= cls.is_load;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: directed scenarios plus a randomized run against an ISA-level model.
module tb_decode_issue_stage;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        flush;
    logic        stall_in;
    logic        stall_out;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_r1, rf_r2;
    logic [4:0]  ex_fwd_rd;
    logic        ex_fwd_wen, ex_fwd_load;
    logic [31:0] ex_fwd_data;
    logic [4:0]  mem_fwd_rd;
    logic        mem_fwd_wen;
    logic [31:0] mem_fwd_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_op1, ex_op2, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_is_load;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_issue_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .flush(flush), .stall_in(stall_in), .stall_out(stall_out),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_r1(rf_r1), .rf_r2(rf_r2),
        .ex_fwd_rd(ex_fwd_rd), .ex_fwd_wen(ex_fwd_wen), .ex_fwd_load(ex_fwd_load),
        .ex_fwd_data(ex_fwd_data),
        .mem_fwd_rd(mem_fwd_rd), .mem_fwd_wen(mem_fwd_wen), .mem_fwd_data(mem_fwd_data),
        .wb_rd(wb_rd), .wb_wen(wb_wen), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_is_load(ex_is_load)
    );

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'h0, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1, input int rd,
                                          input logic [6:0] opc);
        return {imm, 5'(rs1), 3'h0, 5'(rd), opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input int rd, input logic [6:0] opc);
        return {imm, 5'(rd), opc};
    endfunction

    // ISA immediate formats, built straight from the instruction-set field layout.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: return 32'($signed(ins[31:20]));
            7'h23: return 32'($signed({ins[31:25], ins[11:7]}));
            7'h63: return 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: return 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default: return 32'h0;
        endcase
    endfunction

    // Walks producers youngest-first; x0 is hard-wired to zero.
    function automatic logic [31:0] ref_operand(input logic [4:0] idx, input logic [31:0] rf_val,
                                                input logic [2:0] en, input logic [2:0][4:0] rd,
                                                input logic [2:0][31:0] dat);
        logic [31:0] v;
        bit found;
        v = rf_val;
        found = 0;
        for (int k = 0; k < 3; k++)
            if (!found && en[k] && rd[k] == idx) begin
                v = dat[k];
                found = 1;
            end
        return (idx == 5'd0) ? 32'h0 : v;
    endfunction

    task automatic set_idle();
        id_valid = 0; id_instr = 32'h0000_0013; id_pc = 0;
        flush = 0; stall_in = 0; rf_r1 = 0; rf_r2 = 0;
        ex_fwd_rd = 0; ex_fwd_wen = 0; ex_fwd_load = 0; ex_fwd_data = 0;
        mem_fwd_rd = 0; mem_fwd_wen = 0; mem_fwd_data = 0;
        wb_rd = 0; wb_wen = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        set_idle();
        repeat (2) @(negedge clk);
        n_vec++;
        if (ex_valid !== 1'b0 || ex_pc !== RST_PC) begin
            n_err++; $display("FAIL reset_state: valid=%b pc=%h, required valid=0 pc=%h", ex_valid, ex_pc, RST_PC);
        end
        n_vec++;
        if ({ex_op1, ex_op2, ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_is_load} !== '0) begin
            n_err++; $display("FAIL reset_fields: op1=%h op2=%h imm=%h rd=%0d opc=%h, required all 0",
                              ex_op1, ex_op2, ex_imm, ex_rd, ex_opcode);
        end
        rst = 0;
        id_valid = 1; id_instr = enc_r(3, 1, 2); id_pc = 32'h40;
        @(posedge clk); #1;
        n_vec++;
        if (ex_valid !== 1'b1 || ex_pc !== 32'h40) begin
            n_err++; $display("FAIL reset_release_capture: valid=%b pc=%h, required 1 / 00000040", ex_valid, ex_pc);
        end
        @(negedge clk);
        stall_in = 1;
        #1 rst = 1;
        #1;
        n_vec++;
        if (ex_valid !== 1'b0 || ex_pc !== RST_PC || stall_out !== 1'b1) begin
            n_err++; $display("FAIL reset_mid_stall: valid=%b pc=%h stall_out=%b, required 0 %h 1",
                              ex_valid, ex_pc, stall_out, RST_PC);
        end
        stall_in = 0; id_valid = 0;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL reset_stall_out: stall_out=%b, required 0", stall_out);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_ex_forward();
        @(negedge clk);
        set_idle();
        id_valid = 1; id_instr = enc_r(3, 1, 2); id_pc = 32'h80;
        rf_r1 = 32'h11; rf_r2 = 32'h22;
        ex_fwd_rd = 1; ex_fwd_wen = 1; ex_fwd_data = 32'h55;
        @(posedge clk); #1;
        n_vec++;
        if (ex_op1 !== 32'h55 || ex_op2 !== 32'h22 || ex_rd !== 5'd3 || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL ex_forward: op1=%h op2=%h rd=%0d valid=%b, required 55 22 3 1",
                              ex_op1, ex_op2, ex_rd, ex_valid);
        end
    endtask

    task automatic test_fwd_priority();
        logic [31:0] exp_v [3];
        exp_v = '{32'hA, 32'hB, 32'hC};
        for (int step = 0; step < 3; step++) begin
            @(negedge clk);
            set_idle();
            id_valid = 1; id_instr = enc_r(4, 1, 0); rf_r1 = 32'hD;
            ex_fwd_rd = 1;  ex_fwd_wen = (step < 1); ex_fwd_data = 32'hA;
            mem_fwd_rd = 1; mem_fwd_wen = (step < 2); mem_fwd_data = 32'hB;
            wb_rd = 1;      wb_wen = 1;               wb_data = 32'hC;
            @(posedge clk); #1;
            n_vec++;
            if (ex_op1 !== exp_v[step]) begin
                n_err++; $display("FAIL fwd_priority_%0d: op1=%h, required %h", step, ex_op1, exp_v[step]);
            end
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        set_idle();
        id_valid = 1; id_instr = enc_i(12'd7, 0, 5, 7'h13); rf_r1 = 32'h123;
        ex_fwd_rd = 0; ex_fwd_wen = 1; ex_fwd_data = 32'hFF;
        mem_fwd_rd = 0; mem_fwd_wen = 1; mem_fwd_data = 32'hEE;
        @(posedge clk); #1;
        n_vec++;
        if (ex_op1 !== 32'h0 || ex_imm !== 32'h7 || ex_rd !== 5'd5) begin
            n_err++; $display("FAIL x0_no_forward: op1=%h imm=%h rd=%0d, required 0 7 5", ex_op1, ex_imm, ex_rd);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        set_idle();
        id_valid = 1; id_instr = enc_r(2, 1, 1); id_pc = 32'h100;
        ex_fwd_rd = 1; ex_fwd_wen = 1; ex_fwd_load = 1; ex_fwd_data = 32'hBAD;
        #1;
        n_vec++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL load_use_stall: stall_out=%b, required 1", stall_out);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ex_valid !== 1'b0 || ex_rd !== 5'd0 || ex_is_load !== 1'b0) begin
            n_err++; $display("FAIL load_use_bubble: valid=%b rd=%0d is_load=%b, required 0 0 0",
                              ex_valid, ex_rd, ex_is_load);
        end
        @(negedge clk);
        ex_fwd_wen = 0; ex_fwd_load = 0; ex_fwd_rd = 0;
        mem_fwd_rd = 1; mem_fwd_wen = 1; mem_fwd_data = 32'h77;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL load_use_release: stall_out=%b, required 0", stall_out);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ex_valid !== 1'b1 || ex_op1 !== 32'h77 || ex_op2 !== 32'h77 || ex_rd !== 5'd2 || ex_pc !== 32'h100) begin
            n_err++; $display("FAIL load_use_issue: valid=%b op1=%h op2=%h rd=%0d pc=%h, required 1 77 77 2 100",
                              ex_valid, ex_op1, ex_op2, ex_rd, ex_pc);
        end
        @(negedge clk);
        set_idle();
        id_valid = 1; id_instr = enc_u(20'h12345, 1, 7'h37);
        ex_fwd_rd = 1; ex_fwd_wen = 1; ex_fwd_load = 1;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL lui_no_stall: stall_out=%b, required 0", stall_out);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ex_valid !== 1'b1 || ex_imm !== 32'h1234_5000 || ex_rd !== 5'd1 || ex_is_load !== 1'b0) begin
            n_err++; $display("FAIL lui_issue: valid=%b imm=%h rd=%0d ld=%b, required 1 12345000 1 0",
                              ex_valid, ex_imm, ex_rd, ex_is_load);
        end
    endtask

    task automatic test_flush_stall();
        @(negedge clk);
        set_idle();
        id_valid = 1; id_instr = enc_r(6, 1, 2);
        @(posedge clk); #1;
        @(negedge clk);
        flush = 1; stall_in = 1;
        #1;
        n_vec++;
        if (stall_out !== 1'b1) begin
            n_err++; $display("FAIL flush_stall_out: stall_out=%b, required 1", stall_out);
        end
        @(posedge clk); #1;
        n_vec++;
        if (ex_valid !== 1'b0) begin
            n_err++; $display("FAIL flush_beats_stall: valid=%b, required 0", ex_valid);
        end
        @(negedge clk);
        stall_in = 0; flush = 1;
        ex_fwd_rd = 1; ex_fwd_wen = 1; ex_fwd_load = 1;
        #1;
        n_vec++;
        if (stall_out !== 1'b0) begin
            n_err++; $display("FAIL flush_masks_hazard: stall_out=%b, required 0", stall_out);
        end
    endtask

    task automatic test_stall_hold();
        @(negedge clk);
        set_idle();
        id_valid = 1; id_instr = enc_i(12'hFFB, 2, 9, 7'h13); id_pc = 32'h200; rf_r1 = 32'h100;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            stall_in = 1;
            id_instr = $urandom; id_pc = $urandom; rf_r1 = $urandom; rf_r2 = $urandom;
            id_valid = 1'($urandom);
            #1;
            n_vec++;
            if (stall_out !== 1'b1) begin
                n_err++; $display("FAIL stall_hold_out_%0d: stall_out=%b, required 1", c, stall_out);
            end
            @(posedge clk); #1;
            n_vec++;
            if (ex_valid !== 1'b1 || ex_pc !== 32'h200 || ex_op1 !== 32'h100 || ex_imm !== 32'hFFFF_FFFB ||
                ex_rd !== 5'd9 || ex_opcode !== 7'h13) begin
                n_err++; $display("FAIL stall_hold_%0d: valid=%b pc=%h op1=%h imm=%h rd=%0d opc=%h, required 1 200 100 fffffffb 9 13",
                                  c, ex_valid, ex_pc, ex_op1, ex_imm, ex_rd, ex_opcode);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_random();
        logic [6:0]  opcs [12];
        logic [31:0] ins;
        logic [6:0]  opc;
        logic        u1, u2, wr, hz, e_stall;
        logic [2:0]        s_en;
        logic [2:0][4:0]   s_rd;
        logic [2:0][31:0]  s_dat;
        logic        m_valid, m_ld, m_f7, m_def, m_rdl_def;
        logic [31:0] m_pc, m_op1, m_op2, m_imm;
        logic [4:0]  m_rd;
        logic [6:0]  m_opc;
        logic [2:0]  m_f3;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F, 7'h7F};
        @(negedge clk);
        set_idle();
        rst = 1;
        @(negedge clk);
        rst = 0;
        m_valid = 0; m_pc = RST_PC; m_op1 = 0; m_op2 = 0; m_imm = 0; m_rd = 0;
        m_opc = 0; m_f3 = 0; m_f7 = 0; m_ld = 0; m_def = 1; m_rdl_def = 1;
        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            ins = $urandom;
            ins[6:0]   = opcs[$urandom_range(0, 11)];
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            id_instr = ins;
            id_pc = $urandom;
            id_valid = ($urandom_range(0, 4) != 0);
            flush = ($urandom_range(0, 9) == 0);
            stall_in = ($urandom_range(0, 6) == 0);
            rf_r1 = $urandom; rf_r2 = $urandom;
            ex_fwd_rd = 5'($urandom_range(0, 3)); ex_fwd_wen = 1'($urandom);
            ex_fwd_load = ($urandom_range(0, 2) == 0); ex_fwd_data = $urandom;
            mem_fwd_rd = 5'($urandom_range(0, 3)); mem_fwd_wen = 1'($urandom); mem_fwd_data = $urandom;
            wb_rd = 5'($urandom_range(0, 3)); wb_wen = 1'($urandom); wb_data = $urandom;

            opc = ins[6:0];
            u1 = !(opc inside {7'h37, 7'h17, 7'h6F});
            u2 = (opc inside {7'h33, 7'h23, 7'h63});
            wr = (opc inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17});
            hz = id_valid && ex_fwd_load && ex_fwd_wen && ex_fwd_rd != 0 &&
                 ((u1 && ins[19:15] == ex_fwd_rd) || (u2 && ins[24:20] == ex_fwd_rd));
            e_stall = stall_in || (hz && !flush);
            s_en  = {wb_wen, mem_fwd_wen, ex_fwd_wen && !ex_fwd_load};
            s_rd  = {wb_rd, mem_fwd_rd, ex_fwd_rd};
            s_dat = {wb_data, mem_fwd_data, ex_fwd_data};

            #1;
            n_vec++;
            if (stall_out !== e_stall || rf_rs1 !== ins[19:15] || rf_rs2 !== ins[24:20]) begin
                n_err++; $display("FAIL rand_comb_%0d: stall_out=%b rs1=%0d rs2=%0d, required %b %0d %0d",
                                  it, stall_out, rf_rs1, rf_rs2, e_stall, ins[19:15], ins[24:20]);
            end

            if (flush) begin
                m_valid = 0; m_def = 0; m_rdl_def = 0;
            end else if (!stall_in) begin
                if (hz) begin
                    m_valid = 0; m_rd = 0; m_ld = 0; m_def = 0; m_rdl_def = 1;
                end else begin
                    m_valid = id_valid; m_pc = id_pc; m_imm = ref_imm(ins);
                    m_op1 = ref_operand(ins[19:15], rf_r1, s_en, s_rd, s_dat);
                    m_op2 = ref_operand(ins[24:20], rf_r2, s_en, s_rd, s_dat);
                    m_rd = wr ? ins[11:7] : 5'd0; m_opc = opc; m_f3 = ins[14:12];
                    m_f7 = ins[30]; m_ld = (opc == 7'h03); m_def = 1; m_rdl_def = 1;
                end
            end

            @(posedge clk); #1;
            n_vec++;
            if (ex_valid !== m_valid) begin
                n_err++; $display("FAIL rand_valid_%0d: valid=%b, required %b", it, ex_valid, m_valid);
            end
            if (m_rdl_def) begin
                n_vec++;
                if (ex_rd !== m_rd || ex_is_load !== m_ld) begin
                    n_err++; $display("FAIL rand_rd_%0d: rd=%0d ld=%b, required %0d %b", it, ex_rd, ex_is_load, m_rd, m_ld);
                end
            end
            if (m_def) begin
                n_vec++;
                if (ex_pc !== m_pc || ex_op1 !== m_op1 || ex_op2 !== m_op2 || ex_imm !== m_imm) begin
                    n_err++; $display("FAIL rand_data_%0d: pc=%h op1=%h op2=%h imm=%h, required %h %h %h %h",
                                      it, ex_pc, ex_op1, ex_op2, ex_imm, m_pc, m_op1, m_op2, m_imm);
                end
                n_vec++;
                if ({ex_opcode, ex_funct3, ex_funct7b5} !== {m_opc, m_f3, m_f7}) begin
                    n_err++; $display("FAIL rand_ctrl_%0d: opc=%h f3=%h f7b5=%b, required %h %h %b",
                                      it, ex_opcode, ex_funct3, ex_funct7b5, m_opc, m_f3, m_f7);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_fwd_priority();
        test_x0();
        test_load_use();
        test_flush_stall();
        test_stall_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
